// File: rtl/chunked_add_sequencer.sv
// Wide adder front end that time-multiplexes one CHUNK-bit ripple adder over N = WIDTH/CHUNK slices.
// Optional subtract support is enabled by defining CHUNKADD_SUB_EN.

module ripple_carry_adder #(
   parameter int NUMBITS = 8
) (
   input  logic [NUMBITS-1:0] A,
   input  logic [NUMBITS-1:0] B,
   input  logic               carryin,
   output logic [NUMBITS-1:0] result,
   output logic               carryout
);

   always_comb begin : ripple
      logic c;
      c      = carryin;
      result = '0;
      for (int i = 0; i < NUMBITS; i++) begin
         result[i] = A[i] ^ B[i] ^ c;
         c         = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
      end
      carryout = c;
   end

endmodule

// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one slice per cycle through the shared adder
// DONE  | result held until the consumer takes it
module chunked_add_sequencer #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             carryin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carryout
);

   localparam int N     = WIDTH / CHUNK;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               carry_q, carry_d;
   logic [IDX_W-1:0]   idx_q, idx_d;

   logic [CHUNK-1:0]   slice_a;
   logic [CHUNK-1:0]   slice_b;
   logic [CHUNK-1:0]   slice_sum;
   logic               slice_cout;

   logic               sub_eff;
   logic [WIDTH-1:0]   b_load;
   logic               carry_load;

`ifdef CHUNKADD_SUB_EN
   assign sub_eff = sub;
`else
   // Port kept so both builds share one port list; value has no effect here.
   logic sub_unused;
   assign sub_unused = sub;
   assign sub_eff    = 1'b0;
`endif

   assign b_load     = sub_eff ? ~B   : B;
   assign carry_load = sub_eff ? 1'b1 : carryin;

   assign slice_a = a_q[idx_q*CHUNK +: CHUNK];
   assign slice_b = b_q[idx_q*CHUNK +: CHUNK];

   ripple_carry_adder #(
      .NUMBITS (CHUNK)
   ) u_adder (
      .A        (slice_a),
      .B        (slice_b),
      .carryin  (carry_q),
      .result   (slice_sum),
      .carryout (slice_cout)
   );

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      carry_d  = carry_q;
      idx_d    = idx_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d      = A;
               b_d      = b_load;
               carry_d  = carry_load;
               result_d = '0;
               idx_d    = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            result_d[idx_q*CHUNK +: CHUNK] = slice_sum;
            carry_d = slice_cout;
            if (idx_q == IDX_W'(N-1)) begin
               state_d = DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         idx_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         idx_q    <= idx_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   // Outside DONE the carry register holds a partial or input carry, so mask it.
   assign carryout  = (state_q == DONE) & carry_q;

endmodule

// File: tb/tb_chunked_add_sequencer.sv
// Self-checking bench for chunked_add_sequencer (WIDTH=32, CHUNK=8) against an arithmetic reference model.
module tb_chunked_add_sequencer;

   localparam int WIDTH = 32;
   localparam int CHUNK = 8;
   localparam int N     = WIDTH / CHUNK;

   logic             clk;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             carryin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carryout;

   int n_checks = 0;
   int n_fail   = 0;

   chunked_add_sequencer #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .carryin   (carryin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carryout  (carryout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain unsigned arithmetic on the operands as presented at acceptance.
   function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic cin, input logic s);
      logic [WIDTH:0] r;
`ifdef CHUNKADD_SUB_EN
      if (s) begin
         r[WIDTH-1:0] = a - b;
         r[WIDTH]     = (a >= b);
         return r;
      end
`endif
      r = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      return r;
   endfunction

   task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                        input logic s, input int hold, input bit busy_poke, input string tag);
      logic [WIDTH:0] exp;
      int             lat;
      logic [WIDTH-1:0] r0;
      logic           c0;
      exp = model(a, b, cin, s);
      lat = 0;
      while (!in_ready && lat < 20) begin
         tick();
         lat++;
      end
      check({tag, "_in_ready"}, in_ready, 1'b1);
      in_valid  = 1'b1;
      A         = a;
      B         = b;
      carryin   = cin;
      sub       = s;
      out_ready = 1'b0;
      tick();
      // Operands are scrambled after acceptance; the block must ignore them.
      A       = busy_poke ? '1 : WIDTH'($urandom);
      B       = busy_poke ? '1 : WIDTH'($urandom);
      carryin = 1'($urandom);
      sub     = 1'($urandom);
      in_valid = busy_poke;
      lat = 0;
      while (!out_valid && lat < 20) begin
         if (busy_poke) check({tag, "_busy_in_ready"}, in_ready, 1'b0);
         tick();
         lat++;
      end
      in_valid = 1'b0;
      check({tag, "_latency"}, lat, N);
      check({tag, "_result"}, result, exp[WIDTH-1:0]);
      check({tag, "_carryout"}, carryout, exp[WIDTH]);
      r0 = result;
      c0 = carryout;
      for (int i = 0; i < hold; i++) begin
         tick();
         check({tag, "_hold_valid"}, out_valid, 1'b1);
         check({tag, "_hold_result"}, result, r0);
         check({tag, "_hold_carry"}, carryout, c0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_after_valid"}, out_valid, 1'b0);
      check({tag, "_after_ready"}, in_ready, 1'b1);
   endtask

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      A         = '0;
      B         = '0;
      carryin   = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b0;

      for (int i = 0; i < 4; i++) begin
         in_valid = ~in_valid;
         A        = WIDTH'($urandom);
         B        = WIDTH'($urandom);
         tick();
         check("rst_in_ready", in_ready, 1'b1);
         check("rst_out_valid", out_valid, 1'b0);
         check("rst_result", result, '0);
         check("rst_carryout", carryout, 1'b0);
      end
      in_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();

      do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0, "carry_chain");
      do_op(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 5, 1'b0, "backpressure");
      do_op(32'h0102_0304, 32'h0A0B_0C0D, 1'b0, 1'b0, 1, 1'b1, "busy");
      do_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 0, 1'b0, "subtract");
      do_op(32'h0000_0009, 32'h0000_0003, 1'b1, 1'b1, 0, 1'b0, "sub_nob");

      for (int k = 0; k < 25; k++) begin
         do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
               int'($urandom_range(0, 3)), 1'b0, "random");
      end

      // Abort an operation two edges into RUN.
      in_valid = 1'b1;
      A        = 32'hDEAD_BEEF;
      B        = 32'h1234_5678;
      carryin  = 1'b0;
      sub      = 1'b0;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      #1;
      check("midrst_in_ready", in_ready, 1'b1);
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_result", result, '0);
      tick();
      reset = 1'b1;
      for (int i = 0; i < 2 * N; i++) begin
         tick();
         check("midrst_no_valid", out_valid, 1'b0);
      end
      do_op(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0, "post_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
